dual_issue_sched: RTL and testbench
===================================

// Module: dual_issue_sched
// PURPOSE
//  Issue-slot scheduler between the fetch pair buffer and the dual decode stage.
//  Each cycle it offers an instruction pair (slot0 older, slot1 younger) to the backend.
//  Issues both instructions together when the decode hazard check allows it.
//  Otherwise splits the pair: slot0 issues now, slot1 is held and issues alone on a later cycle.
// PARAMETERS
//  pc_width_p    32  width of the instruction PC
//  cnt_width_p   32  width of the stats counters (only with DUAL_ISSUE_STATS_EN)
// PORTS
//  clk_i           in   1           clock
//  reset_n_i       in   1           asynchronous, active-low reset
//  pair_v_i        in   2           per-slot valid from fetch; 2'b10 is illegal (assertion)
//  pair_instr_i    in   2x32        instruction_s [1:0]; [0] is the older instruction
//  pair_pc_i       in   pc_width_p  PC of slot0; slot1 PC = pair_pc_i + 4
//  pair_ready_o    out  1           pair consumed this cycle
//  has_dep_i       in   1           RAW/WAW hazard between slot0 and slot1, from the dual decoder
//  slot0_ctrl_i    in   1           slot0 is a branch, jal, jalr or fence (changes the PC)
//  issue_v_o       out  2           per-slot issue valid to the backend
//  issue_instr_o   out  2x32        issued instructions
//  issue_pc_o      out  pc_width_p  PC of issue slot0
//  issue_ready_i   in   1           backend accepts this cycle's issue
//  flush_i         in   1           redirect/mispredict; discards all held state
// BEHAVIOUR
//  - Reset values: state=S_PAIR, hold_v=0, issue_v_o=0, pair_ready_o=0.
//  - States:
//     S_PAIR   passes the input pair through to the issue ports
//     S_SECOND presents the held slot1
//  - split = pair_v_i[1] & (has_dep_i | slot0_ctrl_i).
//  - S_PAIR, pair_v_i==0: issue_v_o=0, pair_ready_o=0.
//  - S_PAIR, no split:
//     issue_v_o=pair_v_i, issue_* = pair_* combinationally (0-cycle latency)
//     pair_ready_o=issue_ready_i
//  - S_PAIR, split:
//     issue_v_o=2'b01, only slot0 is presented
//     pair_ready_o=issue_ready_i
//     on handshake: hold_instr<=pair_instr_i[1], hold_pc<=pair_pc_i+4, hold_v<=1, next S_SECOND
//  - S_SECOND: issue_v_o=2'b01, issue_*=hold_*, pair_ready_o=0.
//     on issue_ready_i: hold_v<=0, next S_PAIR
//     the next pair is not presented in the same cycle (1 bubble per split)
//  - Backpressure: with issue_ready_i=0, outputs stay stable and no state changes.
//     The held slot1 is never lost.
//  - flush_i has highest priority in every state:
//     issue_v_o=0, pair_ready_o=0, hold_v<=0, next S_PAIR
//     fetch flushes its own buffer
//  - Simultaneous flush_i and issue_ready_i: the flush wins; nothing counts as issued.
//  - Reset asserted mid-operation: hold cleared asynchronously; issue_v_o drops to 0 immediately.
//  - PC add wraps modulo 2^pc_width_p.
// CONFIGURATION
//  DUAL_ISSUE_STATS_EN defined:
//   - adds outputs pair_cnt_o[cnt_width_p] and split_cnt_o[cnt_width_p], both reset to 0
//   - pair_cnt_o +1 on each issue handshake with issue_v_o==2'b11
//   - split_cnt_o +1 on each split handshake in S_PAIR
//   - counters wrap at 2^cnt_width_p; flush does not clear them
//  DUAL_ISSUE_STATS_EN undefined: the ports and counters are absent; scheduling behaviour is identical.
// STRUCTURE
//  - Package bsg_vanilla_pkg gets:
//     dual_issue_state_e {S_PAIR, S_SECOND}
//     dual_issue_slot_s {instr, pc}
//     constant instr_bytes_gp = 4
//  - Sub-module dual_issue_stats: the two counters, instantiated only under DUAL_ISSUE_STATS_EN.
//  - FSM, hold register and issue muxing stay in this module.
// TESTING
//  1 Independent pair: add x1 + add x2, has_dep_i=0, ready=1
//     -> issue_v_o=11 in the same cycle, pair_ready_o=1, state stays S_PAIR
//  2 RAW pair: add x1 ; add x3,x1, has_dep_i=1, pc=0x100
//     -> cycle0 issue_v_o=01 pc 0x100; cycle1 issue_v_o=01 pc 0x104 slot1 instr; cycle2 next pair
//  3 Branch in slot0 (slot0_ctrl_i=1), independent slot1
//     -> split as in test 2; flush_i in cycle1 -> issue_v_o=0, hold dropped, S_PAIR
//  4 Split with issue_ready_i=0 for 3 cycles in S_SECOND
//     -> held instr and PC stable for 3 cycles, issues on cycle 4, exactly once
//  5 Single-valid pair_v_i=01 with has_dep_i=1
//     -> no split, issue_v_o=01, pair_ready_o=1; async reset mid-S_SECOND -> issue_v_o=0 before next edge
//  6 STATS_EN build: 5 independent pairs, 3 splits
//     -> pair_cnt_o=5, split_cnt_o=3; cnt_width_p=4 after 16 pairs -> pair_cnt_o wraps to 0

Source files
------------

// File: rtl/bsg_vanilla_pkg.sv
// Shared types for the vanilla core front end: instruction layout, dual-issue FSM states and slot record.
package bsg_vanilla_pkg;

  localparam int instr_bytes_gp = 4;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] op;
  } instruction_s;

  typedef enum logic [0:0] {
    S_PAIR   = 1'b0,
    S_SECOND = 1'b1
  } dual_issue_state_e;

  typedef struct packed {
    instruction_s instr;
    logic [31:0]  pc;
  } dual_issue_slot_s;

endpackage

// File: rtl/dual_issue_stats.sv
// Issue statistics for the dual-issue scheduler: full-pair issues and pair splits, free-running and wrapping.
module dual_issue_stats #(
  parameter int cnt_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   pair_inc_i,
  input  logic                   split_inc_i,
  output logic [cnt_width_p-1:0] pair_cnt_o,
  output logic [cnt_width_p-1:0] split_cnt_o
);

  logic [cnt_width_p-1:0] pair_cnt_q, pair_cnt_d;
  logic [cnt_width_p-1:0] split_cnt_q, split_cnt_d;

  assign pair_cnt_d  = pair_cnt_q + cnt_width_p'(pair_inc_i);
  assign split_cnt_d = split_cnt_q + cnt_width_p'(split_inc_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pair_cnt_q  <= '0;
      split_cnt_q <= '0;
    end else begin
      pair_cnt_q  <= pair_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign pair_cnt_o  = pair_cnt_q;
  assign split_cnt_o = split_cnt_q;

endmodule

// File: rtl/dual_issue_sched.sv
// Issue-slot scheduler: issues fetch pairs together or splits them, holding slot1 for a later cycle.
// Optional build macro DUAL_ISSUE_STATS_EN adds pair/split statistics counters.
module dual_issue_sched
  import bsg_vanilla_pkg::*;
#(
  parameter int pc_width_p  = 32,
  parameter int cnt_width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [1:0]             pair_v_i,
  input  instruction_s [1:0]     pair_instr_i,
  input  logic [pc_width_p-1:0]  pair_pc_i,
  output logic                   pair_ready_o,
  input  logic                   has_dep_i,
  input  logic                   slot0_ctrl_i,
  output logic [1:0]             issue_v_o,
  output instruction_s [1:0]     issue_instr_o,
  output logic [pc_width_p-1:0]  issue_pc_o,
  input  logic                   issue_ready_i,
  input  logic                   flush_i
`ifdef DUAL_ISSUE_STATS_EN
  ,
  output logic [cnt_width_p-1:0] pair_cnt_o,
  output logic [cnt_width_p-1:0] split_cnt_o
`endif
);

  dual_issue_state_e     state_q, state_d;
  logic                  hold_v_q, hold_v_d;
  instruction_s          hold_instr_q, hold_instr_d;
  logic [pc_width_p-1:0] hold_pc_q, hold_pc_d;
  logic                  split;
  logic [pc_width_p-1:0] slot1_pc;

  assign split    = pair_v_i[1] & (has_dep_i | slot0_ctrl_i);
  assign slot1_pc = pair_pc_i + pc_width_p'(instr_bytes_gp);

  // Outputs are combinational from state and inputs; reset forces them idle without waiting for a clock.
  always_comb begin
    state_d       = state_q;
    hold_v_d      = hold_v_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    issue_v_o     = 2'b00;
    pair_ready_o  = 1'b0;
    issue_instr_o = pair_instr_i;
    issue_pc_o    = pair_pc_i;
    if (flush_i) begin
      state_d  = S_PAIR;
      hold_v_d = 1'b0;
    end else begin
      case (state_q)
        S_PAIR: begin
          if (pair_v_i != 2'b00) begin
            issue_v_o    = split ? 2'b01 : pair_v_i;
            pair_ready_o = issue_ready_i;
            if (split && issue_ready_i) begin
              hold_instr_d = pair_instr_i[1];
              hold_pc_d    = slot1_pc;
              hold_v_d     = 1'b1;
              state_d      = S_SECOND;
            end
          end
        end
        S_SECOND: begin
          issue_v_o        = {1'b0, hold_v_q};
          issue_instr_o[0] = hold_instr_q;
          issue_instr_o[1] = '0;
          issue_pc_o       = hold_pc_q;
          if (issue_ready_i) begin
            hold_v_d = 1'b0;
            state_d  = S_PAIR;
          end
        end
        default: state_d = S_PAIR;
      endcase
    end
    if (!reset_n_i) begin
      issue_v_o    = 2'b00;
      pair_ready_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_PAIR;
      hold_v_q     <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_v_q     <= hold_v_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // Fetch never presents a younger instruction without the older one.
  assert property (@(posedge clk_i) disable iff (!reset_n_i) pair_v_i != 2'b10);

`ifdef DUAL_ISSUE_STATS_EN
  logic pair_inc, split_inc;

  assign pair_inc  = issue_ready_i & (issue_v_o == 2'b11);
  assign split_inc = (state_q == S_PAIR) & split & issue_ready_i & ~flush_i;

  dual_issue_stats #(
    .cnt_width_p(cnt_width_p)
  ) stats (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .pair_inc_i (pair_inc),
    .split_inc_i(split_inc),
    .pair_cnt_o (pair_cnt_o),
    .split_cnt_o(split_cnt_o)
  );
`endif

endmodule

// File: tb/tb_dual_issue_sched.sv
// Self-checking bench for dual_issue_sched: vector table plus directed split/flush/reset sequences with a scoreboard.
module tb_dual_issue_sched;
  import bsg_vanilla_pkg::*;

  localparam int CntW = 4;

  logic               clk_i = 1'b0;
  logic               reset_n_i;
  logic [1:0]         pairV;
  instruction_s [1:0] pairInstr;
  logic [31:0]        pairPc;
  logic               pairReady;
  logic               hasDep;
  logic               slot0Ctrl;
  logic [1:0]         issueV;
  instruction_s [1:0] issueInstr;
  logic [31:0]        issuePc;
  logic               issueReady;
  logic               flush;
`ifdef DUAL_ISSUE_STATS_EN
  logic [CntW-1:0]    pairCnt;
  logic [CntW-1:0]    splitCnt;
`endif

  dual_issue_sched #(
    .pc_width_p (32),
    .cnt_width_p(CntW)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .pair_v_i     (pairV),
    .pair_instr_i (pairInstr),
    .pair_pc_i    (pairPc),
    .pair_ready_o (pairReady),
    .has_dep_i    (hasDep),
    .slot0_ctrl_i (slot0Ctrl),
    .issue_v_o    (issueV),
    .issue_instr_o(issueInstr),
    .issue_pc_o   (issuePc),
    .issue_ready_i(issueReady),
    .flush_i      (flush)
`ifdef DUAL_ISSUE_STATS_EN
    ,
    .pair_cnt_o   (pairCnt),
    .split_cnt_o  (splitCnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] pc;
  } sb_t;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] pc;
    logic        dep;
    logic        ctrl;
    logic        ready;
    logic        flush;
    logic [1:0]  expV;
    logic        expRdy;
  } vec_t;

  sb_t             sbQ[$];
  vec_t            vecs[9];
  int              total = 0;
  int              bad = 0;
  logic [CntW-1:0] expPairCnt = '0;
  logic [CntW-1:0] expSplitCnt = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives a pair while the scheduler is in S_PAIR and queues what the backend should receive from it.
  task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                               input logic [31:0] pc, input logic dep, input logic ctrl,
                               input logic ready, input logic fl);
    logic isSplit;
    @(posedge clk_i);
    #1;
    pairV        = v;
    pairInstr[0] = i0;
    pairInstr[1] = i1;
    pairPc       = pc;
    hasDep       = dep;
    slot0Ctrl    = ctrl;
    issueReady   = ready;
    flush        = fl;
    isSplit      = v[1] & (dep | ctrl);
    if (!fl && ready && v != 2'b00) begin
      if (isSplit) begin
        sbQ.push_back('{v: 2'b01, i0: i0, i1: 32'h0, pc: pc});
        sbQ.push_back('{v: 2'b01, i0: i1, i1: 32'h0, pc: pc + 32'd4});
        expSplitCnt++;
      end else begin
        sbQ.push_back('{v: v, i0: i0, i1: i1, pc: pc});
        if (v == 2'b11) expPairCnt++;
      end
    end
  endtask

  task automatic holdCycle(input logic ready, input logic fl);
    @(posedge clk_i);
    #1;
    pairV      = 2'b00;
    hasDep     = 1'b0;
    slot0Ctrl  = 1'b0;
    issueReady = ready;
    flush      = fl;
  endtask

  // Every accepted issue must match the oldest queued expectation.
  always @(negedge clk_i) begin : monitor
    sb_t e;
    if (reset_n_i === 1'b1 && issueReady === 1'b1 && issueV !== 2'b00) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_extra actual_v=%0b required=no issue", issueV);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_v", 32'(issueV), 32'(e.v));
        checkOutput("sb_i0", 32'(issueInstr[0]), e.i0);
        checkOutput("sb_pc", issuePc, e.pc);
        if (e.v == 2'b11) checkOutput("sb_i1", 32'(issueInstr[1]), e.i1);
      end
    end
  end

  initial begin
    vecs[0] = '{2'b00, 32'h11, 32'h12, 32'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[1] = '{2'b11, 32'h21, 32'h22, 32'h1010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0};
    vecs[2] = '{2'b11, 32'h31, 32'h32, 32'h1020, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
    vecs[3] = '{2'b11, 32'h41, 32'h42, 32'h1030, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0};
    vecs[4] = '{2'b01, 32'h51, 32'h52, 32'h1040, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1};
    vecs[5] = '{2'b11, 32'h61, 32'h62, 32'h1050, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[6] = '{2'b11, 32'h71, 32'h72, 32'h1060, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    vecs[7] = '{2'b11, 32'h81, 32'h82, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1};
    vecs[8] = '{2'b01, 32'h91, 32'h92, 32'h1070, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};

    reset_n_i    = 1'b0;
    pairV        = 2'b01;
    pairInstr[0] = 32'hAAAA;
    pairInstr[1] = 32'hBBBB;
    pairPc       = 32'h0;
    hasDep       = 1'b0;
    slot0Ctrl    = 1'b0;
    issueReady   = 1'b1;
    flush        = 1'b0;
    #12;
    checkOutput("rst_issue_v", 32'(issueV), 32'h0);
    checkOutput("rst_pair_ready", 32'(pairReady), 32'h0);
`ifdef DUAL_ISSUE_STATS_EN
    checkOutput("rst_pair_cnt", 32'(pairCnt), 32'h0);
    checkOutput("rst_split_cnt", 32'(splitCnt), 32'h0);
`endif
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    pairV     = 2'b00;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].v, vecs[i].i0, vecs[i].i1, vecs[i].pc,
                    vecs[i].dep, vecs[i].ctrl, vecs[i].ready, vecs[i].flush);
      #1;
      checkOutput($sformatf("tbl%0d_v", i), 32'(issueV), 32'(vecs[i].expV));
      checkOutput($sformatf("tbl%0d_rdy", i), 32'(pairReady), 32'(vecs[i].expRdy));
    end

    // Independent pairs back to back stay in S_PAIR.
    applyStimulus(2'b11, 32'h0010_0093, 32'h0020_0113, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("ind_v", 32'(issueV), 32'h3);
    checkOutput("ind_rdy", 32'(pairReady), 32'h1);
    applyStimulus(2'b11, 32'h0030_0193, 32'h0040_0213, 32'h208, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("ind2_v", 32'(issueV), 32'h3);

    // RAW split: slot1 issues alone next cycle, next pair waits one bubble.
    applyStimulus(2'b11, 32'h0010_0093, 32'h0010_81B3, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("raw_c0_v", 32'(issueV), 32'h1);
    checkOutput("raw_c0_pc", issuePc, 32'h100);
    @(posedge clk_i);
    #1;
    pairV        = 2'b11;
    pairInstr[0] = 32'hC0C0;
    pairInstr[1] = 32'hD0D0;
    pairPc       = 32'h108;
    hasDep       = 1'b0;
    #1;
    checkOutput("raw_c1_v", 32'(issueV), 32'h1);
    checkOutput("raw_c1_pc", issuePc, 32'h104);
    checkOutput("raw_c1_instr", 32'(issueInstr[0]), 32'h0010_81B3);
    checkOutput("raw_c1_rdy", 32'(pairReady), 32'h0);
    applyStimulus(2'b11, 32'hC0C0, 32'hD0D0, 32'h108, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("raw_c2_v", 32'(issueV), 32'h3);
    checkOutput("raw_c2_pc", issuePc, 32'h108);

    // Branch split, then flush together with ready drops the held slot1.
    applyStimulus(2'b11, 32'hE0E0, 32'hF0F0, 32'h300, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("br_c0_v", 32'(issueV), 32'h1);
    holdCycle(1'b1, 1'b1);
    void'(sbQ.pop_back());
    #1;
    checkOutput("br_flush_v", 32'(issueV), 32'h0);
    checkOutput("br_flush_rdy", 32'(pairReady), 32'h0);
    applyStimulus(2'b11, 32'h6060, 32'h7070, 32'h400, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("br_after_v", 32'(issueV), 32'h3);

    // Backpressure in S_SECOND: held slot stays stable, then issues once.
    applyStimulus(2'b11, 32'h1111, 32'h2222, 32'h500, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      holdCycle(1'b0, 1'b0);
      #1;
      checkOutput($sformatf("bp%0d_v", c), 32'(issueV), 32'h1);
      checkOutput($sformatf("bp%0d_pc", c), issuePc, 32'h504);
      checkOutput($sformatf("bp%0d_instr", c), 32'(issueInstr[0]), 32'h2222);
      checkOutput($sformatf("bp%0d_rdy", c), 32'(pairReady), 32'h0);
    end
    holdCycle(1'b1, 1'b0);
    #1;
    checkOutput("bp_go_v", 32'(issueV), 32'h1);
    checkOutput("bp_go_pc", issuePc, 32'h504);
    holdCycle(1'b1, 1'b0);
    #1;
    checkOutput("bp_done_v", 32'(issueV), 32'h0);

    // Slot1 PC wraps modulo 2^32.
    applyStimulus(2'b11, 32'h3333, 32'h4444, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0);
    holdCycle(1'b1, 1'b0);
    #1;
    checkOutput("wrap_pc", issuePc, 32'h0);

    // Single valid with dependency does not split; async reset mid-S_SECOND idles outputs at once.
    applyStimulus(2'b01, 32'h5555, 32'h6666, 32'h600, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("single_v", 32'(issueV), 32'h1);
    checkOutput("single_rdy", 32'(pairReady), 32'h1);
    applyStimulus(2'b11, 32'h7777, 32'h8888, 32'h700, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    pairV      = 2'b11;
    issueReady = 1'b0;
    #1;
    checkOutput("rst_mid_pre_v", 32'(issueV), 32'h1);
    reset_n_i = 1'b0;
    void'(sbQ.pop_back());
    expPairCnt  = '0;
    expSplitCnt = '0;
    #1;
    checkOutput("rst_mid_v", 32'(issueV), 32'h0);
    checkOutput("rst_mid_rdy", 32'(pairReady), 32'h0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    pairV     = 2'b00;
    applyStimulus(2'b11, 32'h9999, 32'hAAAB, 32'h800, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("rst_after_v", 32'(issueV), 32'h3);
    checkOutput("rst_after_pc", issuePc, 32'h800);

`ifdef DUAL_ISSUE_STATS_EN
    for (int k = 0; k < 5; k++)
      applyStimulus(2'b11, 32'h100 + k, 32'h200 + k, 32'h900 + 8 * k, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b11, 32'h300 + k, 32'h400 + k, 32'hA00 + 8 * k, 1'b1, 1'b0, 1'b1, 1'b0);
      holdCycle(1'b1, 1'b0);
    end
    holdCycle(1'b0, 1'b0);
    #1;
    checkOutput("stat_pair_cnt", 32'(pairCnt), 32'(expPairCnt));
    checkOutput("stat_split_cnt", 32'(splitCnt), 32'(expSplitCnt));
    for (int k = 0; k < 16; k++)
      applyStimulus(2'b11, 32'h500 + k, 32'h600 + k, 32'hB00 + 8 * k, 1'b0, 1'b0, 1'b1, 1'b0);
    holdCycle(1'b0, 1'b0);
    #1;
    checkOutput("stat_pair_wrap", 32'(pairCnt), 32'(expPairCnt));
`endif

    holdCycle(1'b0, 1'b0);
    #2;
    checkOutput("sb_empty", 32'(sbQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
